// File: rtl/rcu_boot_pkg.sv
// Shared constants and state encoding for the RCU boot sequencer.
// Register offsets are relative to the sequencer BASE_ADDR parameter.
package rcu_boot_pkg;

    localparam logic [7:0] RCU_CTRL_OFS = 8'h00;
    localparam logic [7:0] RCU_RDIV_OFS = 8'h04;
    localparam logic [7:0] RCU_STAT_OFS = 8'h08;
    localparam int STAT_PLLSTRB_BIT = 0;

    typedef enum logic [2:0] {
        IDLE,
        WR_RDIV,
        WR_CTRL,
        RD_STAT,
        GAP,
        DONE,
        ERR
    } state_e;

    function automatic logic [31:0] reg_addr(
        input logic [31:0] base,
        input logic [7:0]  ofs
    );
        return base + {24'h0, ofs};
    endfunction

endpackage

// File: rtl/apb4_rcu_boot_seq_xfer.sv
// Single APB4 transfer engine: SETUP while req is new, ACCESS until pready.
// Holding req after ack starts the next transfer with a fresh SETUP.
module apb4_xfer_engine (
    input  logic        pclk,
    input  logic        presetn,
    input  logic        req,
    input  logic [31:0] addr,
    input  logic        wr,
    input  logic [31:0] wdata,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        err,
    output logic [31:0] paddr,
    output logic [2:0]  pprot,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [31:0] pwdata,
    output logic [3:0]  pstrb,
    input  logic [31:0] prdata,
    input  logic        pready,
    input  logic        pslverr
);
    logic acc_q;
    logic acc_d;

    assign acc_d = req & (~acc_q | ~pready);

    dffr #(.W(1)) u_acc (
        .clk(pclk), .rst_n(presetn), .d(acc_d), .q(acc_q)
    );

    assign ack     = req & acc_q & pready;
    assign err     = ack & pslverr;
    assign rdata   = prdata;
    assign psel    = req;
    assign penable = req & acc_q;
    assign paddr   = addr;
    assign pwrite  = wr;
    assign pwdata  = wdata;
    assign pstrb   = wr ? 4'hF : 4'h0;
    assign pprot   = 3'b000;
endmodule

// File: rtl/rcu_boot_dff.sv
// Shared register cells: plain resettable flop and flop with enable.
// Both reset asynchronously to RV.
module dffr #(
    parameter int           W  = 1,
    parameter logic [W-1:0] RV = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= RV;
        else        q <= d;
    end
endmodule

module dffer #(
    parameter int           W  = 1,
    parameter logic [W-1:0] RV = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  q <= RV;
        else if (en) q <= d;
    end
endmodule

// File: rtl/apb4_rcu_boot_seq.sv
// RCU bring-up sequencer: write RDIV, write CTRL, poll STAT until PLL lock.
// Optional poll timeout enabled by defining RCU_BOOT_TIMEOUT_EN.
module apb4_rcu_boot_seq
    import rcu_boot_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter logic [31:0] RDIV_VAL    = 32'd1229,
    parameter logic [31:0] CTRL_VAL    = 32'd0,
    parameter int          POLL_GAP    = 8,
    parameter int          TIMEOUT_CYC = 65535
) (
    input  logic        pclk,
    input  logic        presetn,
    input  logic        start_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] paddr,
    output logic [2:0]  pprot,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [31:0] pwdata,
    output logic [3:0]  pstrb,
    input  logic [31:0] prdata,
    input  logic        pready,
    input  logic        pslverr
);
    localparam int GW = (POLL_GAP < 2) ? 1 : $clog2(POLL_GAP);

    logic [2:0]    st_q;
    state_e        st;
    state_e        nxt;
    logic          req;
    logic          wr;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic          ack;
    logic          xerr;
    logic [31:0]   rdata;
    logic          lock;
    logic          to_hit;
    logic          start_acc;
    logic [GW-1:0] gcnt;
    logic [GW-1:0] gcnt_d;
    logic          gcnt_en;
    logic          unused_rdata;

    assign st = state_e'(st_q);

    dffr #(.W(3), .RV(3'(IDLE))) u_state (
        .clk(pclk), .rst_n(presetn), .d(3'(nxt)), .q(st_q)
    );

    always_comb begin
        req   = 1'b0;
        wr    = 1'b0;
        addr  = '0;
        wdata = '0;
        unique case (st)
            WR_RDIV: begin
                req   = 1'b1;
                wr    = 1'b1;
                addr  = reg_addr(BASE_ADDR, RCU_RDIV_OFS);
                wdata = RDIV_VAL;
            end
            WR_CTRL: begin
                req   = 1'b1;
                wr    = 1'b1;
                addr  = reg_addr(BASE_ADDR, RCU_CTRL_OFS);
                wdata = CTRL_VAL;
            end
            RD_STAT: begin
                req  = 1'b1;
                addr = reg_addr(BASE_ADDR, RCU_STAT_OFS);
            end
            default: ;
        endcase
    end

    apb4_xfer_engine u_xfer (
        .pclk(pclk), .presetn(presetn),
        .req(req), .addr(addr), .wr(wr), .wdata(wdata),
        .ack(ack), .rdata(rdata), .err(xerr),
        .paddr(paddr), .pprot(pprot), .psel(psel),
        .penable(penable), .pwrite(pwrite),
        .pwdata(pwdata), .pstrb(pstrb),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    assign lock         = rdata[STAT_PLLSTRB_BIT];
    assign unused_rdata = ^rdata;
    assign busy_o       = (st == WR_RDIV) | (st == WR_CTRL) |
                          (st == RD_STAT) | (st == GAP);
    assign start_acc    = start_i & ~busy_o;

    always_comb begin
        nxt = st;
        unique case (st)
            IDLE, DONE, ERR: if (start_i) nxt = WR_RDIV;
            WR_RDIV: if (ack) nxt = xerr ? ERR : WR_CTRL;
            WR_CTRL: if (ack) nxt = xerr ? ERR : RD_STAT;
            RD_STAT: begin
                if (ack) begin
                    if (xerr)        nxt = ERR;
                    else if (lock)   nxt = DONE;
                    else if (to_hit) nxt = ERR;
                    else             nxt = GAP;
                end
            end
            GAP: begin
                if (to_hit)          nxt = ERR;
                else if (gcnt == '0) nxt = RD_STAT;
            end
            default: nxt = IDLE;
        endcase
    end

    // gap counter loads on a no-lock read and counts down to zero
    assign gcnt_en = ((st == RD_STAT) & ack) | ((st == GAP) & (gcnt != '0));
    assign gcnt_d  = (st == RD_STAT) ? GW'(POLL_GAP - 1) : gcnt - 1'b1;

    dffer #(.W(GW)) u_gcnt (
        .clk(pclk), .rst_n(presetn), .en(gcnt_en), .d(gcnt_d), .q(gcnt)
    );

`ifdef RCU_BOOT_TIMEOUT_EN
    logic [31:0] tcnt;
    logic [31:0] tcnt_d;
    logic        polling;

    assign polling = (st == RD_STAT) | (st == GAP);
    assign to_hit  = tcnt >= 32'(TIMEOUT_CYC);
    assign tcnt_d  = !polling ? 32'd0 : (to_hit ? tcnt : tcnt + 32'd1);

    dffr #(.W(32)) u_tcnt (
        .clk(pclk), .rst_n(presetn), .d(tcnt_d), .q(tcnt)
    );
`else
    logic unused_timeout;
    assign unused_timeout = ^32'(TIMEOUT_CYC);
    assign to_hit = 1'b0;
`endif

    dffer #(.W(1)) u_done (
        .clk(pclk), .rst_n(presetn),
        .en(start_acc | (nxt == DONE)),
        .d(nxt == DONE), .q(done_o)
    );

    dffer #(.W(1)) u_err (
        .clk(pclk), .rst_n(presetn),
        .en(start_acc | (nxt == ERR)),
        .d(nxt == ERR), .q(err_o)
    );
endmodule
